rc4_keystream_reader: RTL and testbench
=======================================

# rc4_keystream_reader

Read-side Avalon-MM slave carrying RC4 keystream from the FPGA fabric to the HPS. It accepts bytes from the RC4 core over a valid/ready stream and packs four bytes into each 32-bit word. Packed words are buffered in a FIFO, and the HPS pops them by reading a data register. A status register gives fill level, partial-byte count and a sticky underflow flag. A control write flushes all buffered data.

## Interface
- DEPTH_LOG2, 3: FIFO depth is 2^DEPTH_LOG2 words; legal range 1..7.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- s_byte  in  8  keystream byte from RC4 core.
- s_valid  in  1  s_byte valid.
- s_ready  out  1  byte accepted on edge where s_valid & s_ready.
- avs_address  in  1  0 = DATA, 1 = STATUS/CTRL.
- avs_read  in  1  read strobe, single cycle per transfer.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  write byte lanes.
- avs_readdata  out  32  registered read data.
- avs_readdatavalid  out  1  one-cycle pulse, one cycle after avs_read.

## Operation
- **Packer:**
  - 2-bit byte counter `pcnt` plus a 24-bit holding register.
  - The byte accepted with pcnt = k goes to lane k, bits [8k+7:8k], little-endian.
  - On accepting the byte with pcnt = 3, the word {s_byte, hold[23:0]} is written into the FIFO on the same edge, and pcnt wraps to 0.
- **Input ready:** s_ready = reset_n & (count != 2^DEPTH_LOG2). This is deliberately conservative: no byte is accepted while the FIFO is full, even when pcnt < 3.
- **FIFO:**
  - Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - count is DEPTH_LOG2+1 bits wide.
  - If a push and a pop occur on the same edge, count is unchanged and both pointers advance.
- **DATA read (address 0):**
  - If count > 0: readdata ← head word and the FIFO pops on the same edge.
  - If count = 0: readdata ← 0, no pop, and the underflow flag is set.
- **STATUS read (address 1)** returns:
  - [7:0] count, zero-extended.
  - [9:8] pcnt.
  - [16] empty, i.e. count = 0.
  - [17] full.
  - [31] underflow.
  - All other bits are 0.
  - Values are sampled before this edge's updates.
  - The read clears underflow, unless an underflow event occurs on the same edge (set wins).
- **CTRL write (address 1):**
  - Triggered when avs_byteenable[0] = 1 and avs_writedata[0] = 1.
  - Flush clears pointers, count, pcnt, the holding register and underflow.
  - A byte handshaked in the flush cycle is discarded.
  - Flush takes priority over push in the same cycle.
- **Ignored writes:** a write to address 0, or with byteenable[0] = 0, has no effect.
- **Read + write in the same cycle:** the read is serviced and the write is ignored.

## Timing
- **Reset values:**
  - avs_readdata = 0, avs_readdatavalid = 0, s_ready = 0 while reset_n = 0.
  - count = 0, pcnt = 0, underflow = 0.
- **After reset:** s_ready = 1 on the first cycle after reset_n rises.
- **Read latency:** fixed at 1. avs_readdatavalid is high exactly in cycle N+1 for avs_read in cycle N.
- **Held data:** avs_readdata holds its value until the next read. No waitrequest; reads can be back-to-back every cycle.
- **Push visibility:** a word pushed at edge N is visible to a DATA read issued in cycle N+1.
- **Push while full is impossible:** s_ready is low whenever count = DEPTH, so no push can occur while full.
- **Full with simultaneous pop:** a pop at edge N raises s_ready in cycle N+1.
- **Reset mid-operation:**
  - All buffered and partial data is lost.
  - A read issued in the reset cycle produces no readdatavalid.

## Test plan
1. **Basic pack and read.** Push bytes 0x01..0x08, then read STATUS → 0x00010002 is wrong; the required value is 0x00000002 (count = 2, pcnt = 0, empty = 0). Then two DATA reads → 0x04030201 then 0x08070605, each with readdatavalid exactly one cycle after its read.
2. **Fill to full (DEPTH_LOG2 = 3).**
   - Stream 32 bytes → s_ready low after the 32nd accept; STATUS = 0x00020008.
   - A 33rd byte held with s_valid is not accepted.
   - One DATA read → s_ready high the next cycle and the 33rd byte is accepted.
3. **Underflow.** DATA read on an empty FIFO → readdata 0x00000000. Then STATUS → 0x80010000. A second STATUS read → 0x00010000.
4. **Partial word and flush.**
   - Push 0xAA, 0xBB, 0xCC → STATUS = 0x00010300.
   - Write 0x00000001 to address 1 with byteenable = 4'b0001 → STATUS = 0x00010000.
   - Pushing 0x11..0x14 then gives DATA = 0x14131211.
5. **Wrap-around.** With 4 words preloaded, push and pop concurrently for 40 words → every word matches the expected sequence (byte i = i mod 256) and count stays 4.
6. **Reset mid-operation.** Preload 3 words, then pulse reset_n low for 1 cycle coincident with a DATA read → no readdatavalid. Afterwards STATUS = 0x00010000 and s_ready = 1.

Source files
------------

// File: rtl/rc4_keystream_reader.sv
// RC4 keystream reader: packs stream bytes into 32-bit little-endian words,
// buffers them in a FIFO and hands them to the HPS through an Avalon-MM read slave.
module rc4_keystream_reader #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // Word storage; no reset so it can map onto distributed/block RAM.
    logic [31:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [1:0]            pcnt_q, pcnt_d;
    logic [23:0]           hold_q, hold_d;
    logic                  underflow_q, underflow_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  readdatavalid_q, readdatavalid_d;

    logic        rd_data;
    logic        rd_status;
    logic        flush;
    logic        accept;
    logic        push;
    logic        pop;
    logic        empty;
    logic        full;
    logic [31:0] push_word;
    logic [31:0] status_word;
    logic [7:0]  status_count;
    logic [2:0]  lane_we;

    // Only bit 0 of lane 0 is a control bit; the rest of the write bus is don't-care.
    logic unused_wr;
    assign unused_wr = ^{avs_writedata[31:1], avs_byteenable[3:1]};

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign s_ready = reset_n & ~full;

    assign rd_data   = avs_read & ~avs_address;
    assign rd_status = avs_read &  avs_address;
    // A read in the same cycle wins over any write.
    assign flush     = avs_write & ~avs_read & avs_address
                     & avs_byteenable[0] & avs_writedata[0];

    assign accept    = s_valid & s_ready;
    assign push      = accept & ~flush & (pcnt_q == 2'd3);
    assign pop       = rd_data & ~empty;
    assign push_word = {s_byte, hold_q};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign lane_we[gi] = accept & ~flush & (pcnt_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        status_count = '0;
        status_count[CW-1:0] = count_q;
        status_word = {underflow_q, 13'd0, full, empty, 6'd0, pcnt_q, status_count};
    end

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        pcnt_d          = pcnt_q;
        hold_d          = hold_q;
        underflow_d     = underflow_q;
        readdata_d      = readdata_q;
        readdatavalid_d = avs_read;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pcnt_d      = '0;
            hold_d      = '0;
            underflow_d = 1'b0;
        end else begin
            if (accept) begin
                pcnt_d = pcnt_q + 2'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (lane_we[i]) begin
                    hold_d[8*i +: 8] = s_byte;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end

            // Underflow set takes precedence over the clear-on-status-read.
            if (rd_data && empty) begin
                underflow_d = 1'b1;
            end else if (rd_status) begin
                underflow_d = 1'b0;
            end
        end

        if (rd_data) begin
            readdata_d = empty ? 32'd0 : mem_q[rd_ptr_q];
        end else if (rd_status) begin
            readdata_d = status_word;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            pcnt_q          <= '0;
            hold_q          <= '0;
            underflow_q     <= 1'b0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            pcnt_q          <= pcnt_d;
            hold_q          <= hold_d;
            underflow_q     <= underflow_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_rc4_keystream_reader.sv
// Directed bench for rc4_keystream_reader: an operation table for register-level
// behaviour plus hand-written sequences for full, wrap-around and mid-run reset.
module tb_rc4_keystream_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_ready;
    logic        avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    always #5 clk = ~clk;

    rc4_keystream_reader #(.DEPTH_LOG2(3)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .s_byte            (s_byte),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid)
    );

    localparam int K_PUSH  = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;
    localparam int K_RDWR  = 3;

    typedef struct {
        int          kind;
        logic        addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        string       name;
    } op_t;

    op_t ops[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic void add(input int kind, input logic addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp, input string name);
        op_t o;
        o.kind = kind; o.addr = addr; o.wdata = wdata; o.be = be; o.exp = exp; o.name = name;
        ops.push_back(o);
    endfunction

    function automatic void add_push(input logic [7:0] b);
        add(K_PUSH, 1'b0, {24'd0, b}, 4'h0, 32'd0, "push");
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_byte  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: actual=s_ready_low required=s_ready_high byte=0x%02h", b);
        end else begin
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic do_read(input logic addr, input logic [31:0] req, input string name);
        avs_address = addr;
        avs_read    = 1'b1;
        step();
        avs_read = 1'b0;
        $display("read  %-14s addr=%0d data=0x%08h", name, addr, avs_readdata);
        check32({name, "_data"}, avs_readdata, req);
        check32({name, "_valid"}, {31'd0, avs_readdatavalid}, 32'd1);
    endtask

    task automatic do_write(input logic addr, input logic [31:0] wd, input logic [3:0] be);
        avs_address    = addr;
        avs_write      = 1'b1;
        avs_writedata  = wd;
        avs_byteenable = be;
        step();
        avs_write = 1'b0;
        $display("write addr=%0d data=0x%08h be=%b", addr, wd, be);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic        prev_read;
        int          widx;

        reset_n = 1'b0; s_byte = 8'd0; s_valid = 1'b0; avs_address = 1'b0;
        avs_read = 1'b1; avs_write = 1'b0; avs_writedata = 32'd0; avs_byteenable = 4'h0;

        // Reset state, with a read strobe held during reset.
        for (int i = 0; i < 3; i++) begin
            step();
            check32("rst_s_ready", {31'd0, s_ready}, 32'd0);
            check32("rst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
            check32("rst_rdata", avs_readdata, 32'd0);
        end
        reset_n  = 1'b1;
        avs_read = 1'b0;
        #1;
        check32("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        do_read(1'b1, 32'h0001_0000, "rst_status");

        // Operation table.
        for (int i = 1; i <= 8; i++) add_push(8'(i));
        add(K_READ, 1'b1, 0, 0, 32'h0000_0002, "t1_status");
        add(K_READ, 1'b0, 0, 0, 32'h0403_0201, "t1_data0");
        add(K_READ, 1'b0, 0, 0, 32'h0807_0605, "t1_data1");
        add(K_READ, 1'b0, 0, 0, 32'h0000_0000, "t3_uflow_data");
        add(K_READ, 1'b1, 0, 0, 32'h8001_0000, "t3_status_uf");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0000, "t3_status_clr");
        add_push(8'hAA); add_push(8'hBB); add_push(8'hCC);
        add(K_READ, 1'b1, 0, 0, 32'h0001_0300, "t4_partial");
        add(K_WRITE, 1'b1, 32'h0000_0001, 4'b0001, 0, "t4_flush");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0000, "t4_flushed");
        for (int i = 0; i < 4; i++) add_push(8'(8'h11 + i));
        add(K_READ, 1'b0, 0, 0, 32'h1413_1211, "t4_data");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0000, "t4_empty");
        add_push(8'h55); add_push(8'h66);
        add(K_WRITE, 1'b0, 32'h0000_0001, 4'b0001, 0, "ign_addr0");
        add(K_WRITE, 1'b1, 32'h0000_0001, 4'b1110, 0, "ign_be0");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0200, "ign_status1");
        add(K_WRITE, 1'b1, 32'hFFFF_FFFE, 4'b1111, 0, "ign_bit0");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0200, "ign_status2");
        add(K_WRITE, 1'b1, 32'h0000_0001, 4'b0001, 0, "flush2");
        add(K_READ, 1'b0, 0, 0, 32'h0000_0000, "uf_data");
        add(K_WRITE, 1'b1, 32'h0000_0001, 4'b0001, 0, "flush_uf");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0000, "uf_flushed");
        add_push(8'h77);
        add(K_RDWR, 1'b1, 32'h0000_0001, 4'b0001, 32'h0001_0100, "rdwr_status");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0100, "rdwr_kept");
        add(K_WRITE, 1'b1, 32'h0000_0001, 4'b0001, 0, "flush3");
        add(K_READ, 1'b1, 0, 0, 32'h0001_0000, "flush3_status");

        foreach (ops[i]) begin
            case (ops[i].kind)
                K_PUSH: begin
                    push_byte(ops[i].wdata[7:0]);
                    $display("push  byte=0x%02h", ops[i].wdata[7:0]);
                end
                K_READ: do_read(ops[i].addr, ops[i].exp, ops[i].name);
                K_WRITE: do_write(ops[i].addr, ops[i].wdata, ops[i].be);
                default: begin
                    avs_writedata  = ops[i].wdata;
                    avs_byteenable = ops[i].be;
                    avs_write      = 1'b1;
                    do_read(ops[i].addr, ops[i].exp, ops[i].name);
                    avs_write = 1'b0;
                end
            endcase
            if (ops[i].name == "t1_data1") begin
                step();
                check32("t1_rdv_drop", {31'd0, avs_readdatavalid}, 32'd0);
                check32("t1_rdata_hold", avs_readdata, 32'h0807_0605);
            end
        end

        // Fill to full, hold a 33rd byte, release it with one pop.
        for (int i = 0; i < 32; i++) push_byte(8'(i));
        check32("full_s_ready", {31'd0, s_ready}, 32'd0);
        do_read(1'b1, 32'h0002_0008, "full_status");
        s_byte  = 8'hEE;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check32("full_hold_ready", {31'd0, s_ready}, 32'd0);
        end
        do_read(1'b0, 32'h0302_0100, "full_pop");
        check32("full_pop_ready", {31'd0, s_ready}, 32'd1);
        step();
        s_valid = 1'b0;
        do_read(1'b1, 32'h0000_0107, "full_after");
        do_write(1'b1, 32'h0000_0001, 4'b0001);

        // Wrap-around: 4 words resident, push and pop concurrently.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        prev_read = 1'b0;
        widx = 0;
        for (int j = 16; j < 176; j++) begin
            s_byte  = 8'(j);
            s_valid = 1'b1;
            avs_address = 1'b0;
            avs_read    = (j % 4 == 3);
            if (!s_ready) begin
                checks++;
                failures++;
                $display("FAIL wrap_ready: actual=0 required=1 j=%0d", j);
            end
            step();
            if (avs_read) begin
                avs_read = 1'b0;
                w = {8'(4*widx + 3), 8'(4*widx + 2), 8'(4*widx + 1), 8'(4*widx)};
                $display("read  wrap word %0d data=0x%08h", widx, avs_readdata);
                check32("wrap_data", avs_readdata, w);
                check32("wrap_valid", {31'd0, avs_readdatavalid}, 32'd1);
                widx++;
                prev_read = 1'b1;
            end else begin
                if (!prev_read) check32("wrap_novalid", {31'd0, avs_readdatavalid}, 32'd0);
                prev_read = 1'b0;
            end
        end
        s_valid = 1'b0;
        do_read(1'b1, 32'h0000_0004, "wrap_status");

        // Reset mid-operation with 3 words buffered.
        do_write(1'b1, 32'h0000_0001, 4'b0001);
        for (int i = 0; i < 12; i++) push_byte(8'(8'h20 + i));
        do_read(1'b1, 32'h0000_0003, "pre_rst_status");
        reset_n     = 1'b0;
        avs_address = 1'b0;
        avs_read    = 1'b1;
        #1;
        check32("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        step();
        reset_n  = 1'b1;
        avs_read = 1'b0;
        check32("midrst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
        check32("midrst_rdata", avs_readdata, 32'd0);
        #1;
        check32("midrst_ready_after", {31'd0, s_ready}, 32'd1);
        do_read(1'b1, 32'h0001_0000, "midrst_status");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
